serial2parallel: RTL and testbench
==================================

Name: serial2parallel

Overview:
- Receive-side counterpart of the team's 4-bit parallel-to-serial transmitter.
- Accepts a 1-bit serial stream with a first-bit marker (the transmitter's valid strobe) and reassembles WIDTH-bit words.
- Presents each word on a valid/ready output with a one-word holding register.
- Sits at the far end of the serial link, feeding the word-level datapath; flags resync and overflow conditions.

Parameters:
- WIDTH, 4, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = first serial bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- din  input  1  serial data bit.
- din_en  input  1  din/din_sof are sampled only in cycles where this is 1.
- din_sof  input  1  marks that din carries bit 0 (first bit) of a word.
- dout  output  WIDTH  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid=1.
- sync_err  output  1  one-cycle pulse: marker arrived mid-word.
- overflow  output  1  sticky: a completed word was dropped.
- busy  output  1  1 while in COLLECT.

Behaviour:
- Reset: all registers update only on rising clk; rst=1 at an edge forces the following values, which take priority over all other activity.
  - state=HUNT, bit count=0, shift register=0.
  - dout=0, dout_valid=0, sync_err=0, overflow=0.
- Reset mid-word discards the partial word and any held word.
- Bit sampling: a "bit event" is any edge with din_en=1. Edges with din_en=0 change no state and no count; stretching gaps is legal.
- State HUNT:
  - Bit event with din_sof=0: ignored.
  - Bit event with din_sof=1: captures din as bit 0; count=1; go to COLLECT.
- State COLLECT:
  - Bit event with din_sof=0: captures the next bit; count increments.
  - When the bit with index WIDTH-1 is captured, the word completes; return to HUNT with count=0.
- Resync: bit event with din_sof=1 while in COLLECT (count 1..WIDTH-1):
  - sync_err=1 for exactly the next cycle.
  - The partial word is discarded.
  - The current din is captured as bit 0 of a new word; count=1; stay in COLLECT.
- Back-to-back words: a marker on the bit event immediately after completion is normal (state is HUNT), so sync_err=0. The continuous stream from the transmitter (marker every WIDTH cycles) therefore produces no errors.
- Bit placement:
  - MSB_FIRST=1: bit k goes to dout[WIDTH-1-k].
  - MSB_FIRST=0: bit k goes to dout[k].
- Completion latency: dout/dout_valid update at the same edge that captures the last bit, so the word is visible in the cycle after the last bit was presented.
- Output handshake: a transfer occurs on an edge where dout_valid=1 and dout_ready=1.
  - Transfer with no completion: dout_valid becomes 0 and dout holds its value.
  - Completion with holding register empty, or transfer at the same edge: new word loads and dout_valid=1. A simultaneous transfer and completion is not an overflow.
  - Completion while dout_valid=1 and dout_ready=0: the new word is dropped, the old word is kept, and overflow becomes 1.
  - overflow stays 1 until rst.
- Marker with no following bits: remains in COLLECT indefinitely; there is no timeout.
- dout_ready is ignored when dout_valid=0.

Test Plan:
- Reset: rst=1 for 2 cycles, din_en=1 with random din -> dout=0, dout_valid=0, sync_err=0, overflow=0, busy=0.
- Single word (WIDTH=4, MSB_FIRST=1), dout_ready=1: din_en=1, din_sof on first bit, bits 1,0,1,1 -> dout=4'b1011, dout_valid high exactly one cycle after the 4th bit, sync_err=0.
- Continuous stream with marker every 4 cycles, words A, 5, C, 3 -> dout sequence A, 5, C, 3 every 4 cycles, no sync_err. Same test with MSB_FIRST=0 gives 5, A, 3, C.
- Gapped input: din_en toggles 1,0,1,0 across word 6 (bits 0,1,1,0) -> dout=6; completion on the 4th enabled bit; busy=1 throughout the gaps.
- Resync: marker, bits 1,1, then marker with bits 0,0,1,0 -> sync_err pulses once at the second marker; dout=2; the partial 11 is never output.
- Overflow and simultaneity: dout_ready=0, send words 9 then 4 -> dout stays 9, overflow=1 and remains set. After rst, with dout_ready=1 at the completion edge of the second word -> dout=4, dout_valid stays 1, overflow=0.

Source files
------------

// File: rtl/serial2parallel_if.sv
// Serial-in / word-out bundle for the link receiver; slave is the receiver, master drives the stream.
interface serial2parallel_if #(parameter int WIDTH = 4);
  logic             din;
  logic             din_en;
  logic             din_sof;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             sync_err;
  logic             overflow;
  logic             busy;

  modport slave (
    input  din, din_en, din_sof, dout_ready,
    output dout, dout_valid, sync_err, overflow, busy
  );

  modport master (
    output din, din_en, din_sof, dout_ready,
    input  dout, dout_valid, sync_err, overflow, busy
  );
endinterface

// File: rtl/serial2parallel.sv
// Reassembles WIDTH-bit words from a marked serial stream; word appears the cycle after its last bit.
// One-word holding register: a completion while held and not accepted drops the new word and sets sticky overflow.
module serial2parallel #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                clk,
  input logic                rst,
  serial2parallel_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             resync;

  logic [WIDTH-1:0] dout_q, dout_n;
  logic             valid_q, valid_n;
  logic             sync_err_q;
  logic             overflow_q, overflow_n;

  // Serial bit index k maps to its output position according to bit order.
  function automatic logic [CW-1:0] slot(input logic [CW-1:0] k);
    return MSB_FIRST ? (CW'(WIDTH - 1) - k) : k;
  endfunction

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shreg_n  = shreg;
    word     = '0;
    complete = 1'b0;
    resync   = 1'b0;
    if (bus.din_en) begin
      if (bus.din_sof) begin
        // A marker always restarts a word; mid-word it also discards the partial.
        resync                 = (state == COLLECT);
        shreg_n                = '0;
        shreg_n[slot(CW'(0))]  = bus.din;
        cnt_n                  = CW'(1);
        state_n                = COLLECT;
      end else if (state == COLLECT) begin
        word            = shreg;
        word[slot(cnt)] = bus.din;
        if (cnt == CW'(WIDTH - 1)) begin
          complete = 1'b1;
          state_n  = HUNT;
          cnt_n    = '0;
          shreg_n  = '0;
        end else begin
          shreg_n = word;
          cnt_n   = cnt + CW'(1);
        end
      end
    end
  end

  always_comb begin
    dout_n     = dout_q;
    valid_n    = valid_q;
    overflow_n = overflow_q;
    if (complete) begin
      if (!valid_q || bus.dout_ready) begin
        dout_n  = word;
        valid_n = 1'b1;
      end else begin
        overflow_n = 1'b1;
      end
    end else if (valid_q && bus.dout_ready) begin
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      cnt        <= '0;
      shreg      <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      dout_q     <= dout_n;
      valid_q    <= valid_n;
      sync_err_q <= resync;
      overflow_q <= overflow_n;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = (state == COLLECT);
endmodule

// File: tb/tb_serial2parallel.sv
// Directed bench: MSB-first and LSB-first receivers fed the same serial stream.
module tb_serial2parallel;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial2parallel_if #(.WIDTH(4)) bm ();
  serial2parallel_if #(.WIDTH(4)) bl ();

  assign bl.din        = bm.din;
  assign bl.din_en     = bm.din_en;
  assign bl.din_sof    = bm.din_sof;
  assign bl.dout_ready = bm.dout_ready;

  serial2parallel #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(bm));
  serial2parallel #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(bl));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bm.din_en  = 1'b0;
    bm.din_sof = 1'b0;
    bm.din     = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic sof, input logic b);
    bm.din_en  = 1'b1;
    bm.din_sof = sof;
    bm.din     = b;
    tick();
  endtask

  task automatic send_word(input logic [3:0] w);
    send_bit(1'b1, w[3]);
    send_bit(1'b0, w[2]);
    send_bit(1'b0, w[1]);
    send_bit(1'b0, w[0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bm.dout_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bm.din_en  = 1'b1;
      bm.din_sof = 1'($urandom_range(0, 1));
      bm.din     = 1'($urandom_range(0, 1));
      tick();
    end
    checks++; if (bm.dout !== 4'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", bm.dout); end
    checks++; if (bm.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bm.dout_valid); end
    checks++; if (bm.sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got %b exp 0", bm.sync_err); end
    checks++; if (bm.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", bm.overflow); end
    checks++; if (bm.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bm.busy); end
    checks++; if (bl.dout_valid !== 1'b0 || bl.busy !== 1'b0) begin errors++; $display("FAIL reset_lsb got v=%b b=%b exp 0 0", bl.dout_valid, bl.busy); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_single_word();
    bm.dout_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    checks++; if (bm.dout_valid !== 1'b0 || bm.busy !== 1'b1) begin errors++; $display("FAIL single_pre got v=%b b=%b exp 0 1", bm.dout_valid, bm.busy); end
    send_bit(1'b0, 1'b1);
    checks++; if (bm.dout !== 4'hB) begin errors++; $display("FAIL single_dout got %h exp b", bm.dout); end
    checks++; if (bm.dout_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bm.dout_valid); end
    checks++; if (bm.sync_err !== 1'b0 || bm.busy !== 1'b0) begin errors++; $display("FAIL single_flags got se=%b b=%b exp 0 0", bm.sync_err, bm.busy); end
    checks++; if (bl.dout !== 4'hD) begin errors++; $display("FAIL single_lsb got %h exp d", bl.dout); end
    idle(1);
    checks++; if (bm.dout_valid !== 1'b0 || bm.dout !== 4'hB) begin errors++; $display("FAIL single_consumed got v=%b d=%h exp 0 b", bm.dout_valid, bm.dout); end
  endtask

  task automatic test_stream();
    logic [3:0] words [4];
    logic [3:0] lsb   [4];
    words = '{4'hA, 4'h5, 4'hC, 4'h3};
    lsb   = '{4'h5, 4'hA, 4'h3, 4'hC};
    bm.dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_word(words[i]);
      checks++; if (bm.dout !== words[i] || bm.dout_valid !== 1'b1) begin errors++; $display("FAIL stream_msb%0d got %h v=%b exp %h v=1", i, bm.dout, bm.dout_valid, words[i]); end
      checks++; if (bl.dout !== lsb[i]) begin errors++; $display("FAIL stream_lsb%0d got %h exp %h", i, bl.dout, lsb[i]); end
      checks++; if (bm.sync_err !== 1'b0 || bl.sync_err !== 1'b0) begin errors++; $display("FAIL stream_sync%0d got %b%b exp 00", i, bm.sync_err, bl.sync_err); end
    end
    idle(2);
    checks++; if (bm.overflow !== 1'b0) begin errors++; $display("FAIL stream_overflow got %b exp 0", bm.overflow); end
  endtask

  task automatic test_gapped();
    logic [3:0] bits;
    bits = 4'b0110;
    bm.dout_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_bit(k == 0, bits[3 - k]);
      if (k < 3) begin
        idle(1);
        checks++; if (bm.busy !== 1'b1 || bm.dout_valid !== 1'b0) begin errors++; $display("FAIL gap%0d got b=%b v=%b exp 1 0", k, bm.busy, bm.dout_valid); end
      end
    end
    checks++; if (bm.dout !== 4'h6 || bm.dout_valid !== 1'b1) begin errors++; $display("FAIL gapped_dout got %h v=%b exp 6 v=1", bm.dout, bm.dout_valid); end
    checks++; if (bl.dout !== 4'h6) begin errors++; $display("FAIL gapped_lsb got %h exp 6", bl.dout); end
    idle(1);
  endtask

  task automatic test_resync();
    bm.dout_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    checks++; if (bm.sync_err !== 1'b0) begin errors++; $display("FAIL resync_early got %b exp 0", bm.sync_err); end
    send_bit(1'b1, 1'b0);
    checks++; if (bm.sync_err !== 1'b1 || bl.sync_err !== 1'b1) begin errors++; $display("FAIL resync_pulse got %b%b exp 11", bm.sync_err, bl.sync_err); end
    checks++; if (bm.dout_valid !== 1'b0) begin errors++; $display("FAIL resync_partial got v=%b exp 0", bm.dout_valid); end
    send_bit(1'b0, 1'b0);
    checks++; if (bm.sync_err !== 1'b0) begin errors++; $display("FAIL resync_single got %b exp 0", bm.sync_err); end
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    checks++; if (bm.dout !== 4'h2 || bm.dout_valid !== 1'b1) begin errors++; $display("FAIL resync_dout got %h v=%b exp 2 v=1", bm.dout, bm.dout_valid); end
    checks++; if (bl.dout !== 4'h4) begin errors++; $display("FAIL resync_lsb got %h exp 4", bl.dout); end
    idle(1);
  endtask

  task automatic test_overflow();
    do_reset();
    bm.dout_ready = 1'b0;
    send_word(4'h9);
    checks++; if (bm.dout !== 4'h9 || bm.overflow !== 1'b0) begin errors++; $display("FAIL ovf_first got %h o=%b exp 9 o=0", bm.dout, bm.overflow); end
    send_word(4'h4);
    checks++; if (bm.dout !== 4'h9 || bm.dout_valid !== 1'b1) begin errors++; $display("FAIL ovf_keep got %h v=%b exp 9 v=1", bm.dout, bm.dout_valid); end
    checks++; if (bm.overflow !== 1'b1 || bl.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b%b exp 11", bm.overflow, bl.overflow); end
    idle(3);
    bm.dout_ready = 1'b1;
    tick();
    checks++; if (bm.overflow !== 1'b1 || bm.dout_valid !== 1'b0) begin errors++; $display("FAIL ovf_sticky got o=%b v=%b exp 1 0", bm.overflow, bm.dout_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    checks++; if (bm.overflow !== 1'b0) begin errors++; $display("FAIL b2b_reset_ovf got %b exp 0", bm.overflow); end
    bm.dout_ready = 1'b0;
    send_word(4'h9);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    checks++; if (bm.dout !== 4'h9 || bm.dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_held got %h v=%b exp 9 v=1", bm.dout, bm.dout_valid); end
    bm.dout_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    checks++; if (bm.dout !== 4'h4 || bm.dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_dout got %h v=%b exp 4 v=1", bm.dout, bm.dout_valid); end
    checks++; if (bm.overflow !== 1'b0 || bl.overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b%b exp 00", bm.overflow, bl.overflow); end
    checks++; if (bl.dout !== 4'h2) begin errors++; $display("FAIL b2b_lsb got %h exp 2", bl.dout); end
    idle(2);
  endtask

  initial begin
    rst           = 1'b1;
    bm.din        = 1'b0;
    bm.din_en     = 1'b0;
    bm.din_sof    = 1'b0;
    bm.dout_ready = 1'b0;
    test_reset();
    test_single_word();
    test_stream();
    test_gapped();
    test_resync();
    test_overflow();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
